// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: opcode set, fetch/decode packets, skid states
// and opcode classification helpers.
package decode_stage_pkg;

  localparam int unsigned IMM_BITS     = 14;
  localparam int unsigned CORE_ID_BITS = 4;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [7:0] {
    NOP               = 8'h00,
    ADD               = 8'h01,
    SUB               = 8'h02,
    MUL               = 8'h03,
    MOVE              = 8'h04,
    LOAD              = 8'h10,
    STORE             = 8'h11,
    LOAD_RESTORE_PC   = 8'h12,
    JMP_ALWAYS        = 8'h20,
    JMP_EQUAL         = 8'h21,
    JMP_NOT_EQUAL     = 8'h22,
    JMP_GREATER       = 8'h23,
    JMP_GREATER_EQUAL = 8'h24,
    JMP_LOWER         = 8'h25,
    JMP_LOWER_EQUAL   = 8'h26,
    HALT              = 8'h3F
  } Opcode;

  typedef struct packed {
    logic [31:0] exec_mask;
    logic [63:0] pc;
    logic [31:0] insn;
  } FetchToDecodeBusPacket;

  typedef struct packed {
    logic [CORE_ID_BITS-1:0] core_id;
    logic [31:0]             exec_mask;
    logic [63:0]             pc;
    logic [7:0]              opcode;
    reg_idx_t                rd;
    reg_idx_t                rs1;
    reg_idx_t                rs2;
    logic [63:0]             imm;
    logic                    is_branch;
    logic                    is_mem;
    logic                    is_halt;
    logic                    illegal;
  } DecodeToExecPacket;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic changesControlFlow(input logic [7:0] op);
    case (op)
      JMP_ALWAYS, JMP_EQUAL, JMP_NOT_EQUAL, JMP_GREATER, JMP_GREATER_EQUAL,
      JMP_LOWER, JMP_LOWER_EQUAL, LOAD_RESTORE_PC, HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch_op(input logic [7:0] op);
    return changesControlFlow(op) && (op != HALT);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      LOAD, STORE, LOAD_RESTORE_PC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_valid_op(input logic [7:0] op);
    case (op)
      NOP, ADD, SUB, MUL, MOVE, LOAD, STORE, LOAD_RESTORE_PC,
      JMP_ALWAYS, JMP_EQUAL, JMP_NOT_EQUAL, JMP_GREATER, JMP_GREATER_EQUAL,
      JMP_LOWER, JMP_LOWER_EQUAL, HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_insn_decoder.sv
// Combinational instruction splitter/classifier feeding the decode skid buffer.
module insn_decoder
  import decode_stage_pkg::*;
(
  input  logic [CORE_ID_BITS-1:0] core_id,
  input  logic [31:0]             exec_mask,
  input  logic [63:0]             pc,
  input  logic [31:0]             insn,
  output DecodeToExecPacket       dec_pkt
);

  logic op_valid;

  always_comb begin
    dec_pkt           = '0;
    dec_pkt.core_id   = core_id;
    dec_pkt.exec_mask = exec_mask;
    dec_pkt.pc        = pc;
    dec_pkt.opcode    = insn[7:0];
    dec_pkt.rd        = insn[12:8];
    dec_pkt.rs1       = insn[17:13];
    dec_pkt.rs2       = insn[22:18];
    dec_pkt.imm       = {{(64 - IMM_BITS){insn[31]}}, insn[31:18]};
    op_valid          = is_valid_op(insn[7:0]);
    // Unknown opcodes still flow downstream, but with every class flag cleared.
    dec_pkt.is_branch = op_valid && is_branch_op(insn[7:0]);
    dec_pkt.is_mem    = op_valid && is_mem_op(insn[7:0]);
    dec_pkt.is_halt   = op_valid && (insn[7:0] == HALT);
    dec_pkt.illegal   = !op_valid;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: insn_decoder followed by a two-entry skid buffer with registered
// handshakes. Optional counters are enabled with `define DECODE_STATS_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned CORE_ID = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_valid,
  input  FetchToDecodeBusPacket fetch_pkt,
  output logic                  decode_busy,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output DecodeToExecPacket     exec_pkt
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]           stat_decoded,
  output logic [31:0]           stat_stalls,
  output logic [31:0]           stat_illegal
`endif
);

  localparam logic [CORE_ID_BITS-1:0] CORE_ID_TAG = CORE_ID[CORE_ID_BITS-1:0];

  DecodeToExecPacket dec_pkt;
  skid_state_e       state_q, state_d;
  DecodeToExecPacket out_pkt_q, out_pkt_d;
  DecodeToExecPacket skid_pkt_q, skid_pkt_d;
  logic              exec_valid_q, exec_valid_d;
  logic              decode_busy_q, decode_busy_d;
  logic              accept;

  insn_decoder u_insn_decoder (
    .core_id   (CORE_ID_TAG),
    .exec_mask (fetch_pkt.exec_mask),
    .pc        (fetch_pkt.pc),
    .insn      (fetch_pkt.insn),
    .dec_pkt   (dec_pkt)
  );

  always_comb begin
    state_d    = state_q;
    out_pkt_d  = out_pkt_q;
    skid_pkt_d = skid_pkt_q;
    accept     = fetch_valid && !decode_busy_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_pkt_d = dec_pkt;
          state_d   = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      // Output register is valid here, so exec_ready alone means a drain.
      ST_ONE: begin
        if (accept && exec_ready) begin
          out_pkt_d = dec_pkt;
          state_d   = ST_ONE;
        end else if (accept) begin
          skid_pkt_d = dec_pkt;
          state_d    = ST_FULL;
        end else if (exec_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (exec_ready) begin
          out_pkt_d = skid_pkt_q;
          state_d   = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    // Handshake outputs derive from the next state so they stay purely registered.
    exec_valid_d  = (state_d != ST_EMPTY);
    decode_busy_d = (state_d == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_EMPTY;
      out_pkt_q     <= '0;
      skid_pkt_q    <= '0;
      exec_valid_q  <= 1'b0;
      decode_busy_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_pkt_q     <= out_pkt_d;
      skid_pkt_q    <= skid_pkt_d;
      exec_valid_q  <= exec_valid_d;
      decode_busy_q <= decode_busy_d;
    end
  end

  assign exec_valid  = exec_valid_q;
  assign decode_busy = decode_busy_q;
  assign exec_pkt    = out_pkt_q;

`ifdef DECODE_STATS_EN
  logic [31:0] decoded_count_q, decoded_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] illegal_count_q, illegal_count_d;
  logic        handshake;

  always_comb begin
    handshake       = exec_valid_q && exec_ready;
    decoded_count_d = decoded_count_q;
    stall_cycles_d  = stall_cycles_q;
    illegal_count_d = illegal_count_q;
    if (handshake && (decoded_count_q != 32'hFFFF_FFFF)) begin
      decoded_count_d = decoded_count_q + 32'd1;
    end else begin
      decoded_count_d = decoded_count_q;
    end
    if (exec_valid_q && !exec_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (handshake && out_pkt_q.illegal && (illegal_count_q != 32'hFFFF_FFFF)) begin
      illegal_count_d = illegal_count_q + 32'd1;
    end else begin
      illegal_count_d = illegal_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      decoded_count_q <= 32'd0;
      stall_cycles_q  <= 32'd0;
      illegal_count_q <= 32'd0;
    end else begin
      decoded_count_q <= decoded_count_d;
      stall_cycles_q  <= stall_cycles_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign stat_decoded = decoded_count_q;
  assign stat_stalls  = stall_cycles_q;
  assign stat_illegal = illegal_count_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; inputs change and outputs are
// sampled on the falling clock edge.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  fetch_valid;
  FetchToDecodeBusPacket fetch_pkt;
  logic                  decode_busy;
  logic                  exec_valid;
  logic                  exec_ready;
  DecodeToExecPacket     exec_pkt;
`ifdef DECODE_STATS_EN
  logic [31:0]           stat_decoded;
  logic [31:0]           stat_stalls;
  logic [31:0]           stat_illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.CORE_ID(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_valid (fetch_valid),
    .fetch_pkt   (fetch_pkt),
    .decode_busy (decode_busy),
    .exec_valid  (exec_valid),
    .exec_ready  (exec_ready),
    .exec_pkt    (exec_pkt)
`ifdef DECODE_STATS_EN
    ,
    .stat_decoded (stat_decoded),
    .stat_stalls  (stat_stalls),
    .stat_illegal (stat_illegal)
`endif
  );

  function automatic logic [31:0] mk_insn(input logic [7:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [13:0] imm14);
    return {imm14, rs1, rd, op};
  endfunction

  function automatic FetchToDecodeBusPacket mk_pkt(input logic [31:0] mask, input logic [63:0] pc,
                                                   input logic [31:0] insn);
    FetchToDecodeBusPacket p;
    p.exec_mask = mask;
    p.pc        = pc;
    p.insn      = insn;
    return p;
  endfunction

  // Offer one packet with exec_ready high; returns on the falling edge after acceptance.
  task automatic send_one(input FetchToDecodeBusPacket p);
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pkt   = p;
    exec_ready  = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    fetch_valid = 1'b0;
    fetch_pkt   = '0;
    exec_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", exec_valid); end
    checks++; if (decode_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", decode_busy); end
    checks++; if (exec_pkt !== '0) begin errors++; $display("FAIL reset_pkt got %h want 0", exec_pkt); end
`ifdef DECODE_STATS_EN
    checks++; if (stat_illegal !== 32'd0) begin errors++; $display("FAIL reset_stat got %0d want 0", stat_illegal); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_branch_fields;
    send_one(mk_pkt(32'hFFFF_FFFF, 64'h100, mk_insn(JMP_EQUAL, 5'd3, 5'd4, 14'h3FE5)));
    checks++; if (exec_valid !== 1'b1) begin errors++; $display("FAIL br_valid got %b want 1", exec_valid); end
    checks++; if (exec_pkt.is_branch !== 1'b1 || exec_pkt.is_mem !== 1'b0 || exec_pkt.illegal !== 1'b0)
      begin errors++; $display("FAIL br_flags got b%b m%b i%b want 1 0 0", exec_pkt.is_branch, exec_pkt.is_mem, exec_pkt.illegal); end
    checks++; if (exec_pkt.rd !== 5'd3 || exec_pkt.rs1 !== 5'd4 || exec_pkt.rs2 !== 5'd5)
      begin errors++; $display("FAIL br_regs got %0d %0d %0d want 3 4 5", exec_pkt.rd, exec_pkt.rs1, exec_pkt.rs2); end
    checks++; if (exec_pkt.imm !== 64'hFFFF_FFFF_FFFF_FFE5) begin errors++; $display("FAIL br_imm got %h want ffffffffffffffe5", exec_pkt.imm); end
    checks++; if (exec_pkt.pc !== 64'h100 || exec_pkt.exec_mask !== 32'hFFFF_FFFF || exec_pkt.opcode !== 8'h21)
      begin errors++; $display("FAIL br_copy got pc %h mask %h op %h", exec_pkt.pc, exec_pkt.exec_mask, exec_pkt.opcode); end
    checks++; if (exec_pkt.core_id !== 4'd3) begin errors++; $display("FAIL br_core got %0d want 3", exec_pkt.core_id); end
    send_one(mk_pkt(32'h0000_0001, 64'h104, mk_insn(JMP_EQUAL, 5'd3, 5'd4, 14'h3FFF)));
    checks++; if (exec_pkt.imm !== 64'hFFFF_FFFF_FFFF_FFFF || exec_pkt.rs2 !== 5'd31)
      begin errors++; $display("FAIL imm_ones got %h rs2 %0d want all-ones 31", exec_pkt.imm, exec_pkt.rs2); end
    send_one(mk_pkt(32'h0000_0001, 64'h108, mk_insn(MOVE, 5'd1, 5'd2, 14'h1FFF)));
    checks++; if (exec_pkt.imm !== 64'h0000_0000_0000_1FFF || exec_pkt.is_branch !== 1'b0)
      begin errors++; $display("FAIL imm_pos got %h br %b want 1fff 0", exec_pkt.imm, exec_pkt.is_branch); end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (exec_valid !== 1'b1 || exec_pkt.pc !== 64'(4 * (i - 1)))
          begin errors++; $display("FAIL stream_%0d got v%b pc %h want 1 %h", i, exec_valid, exec_pkt.pc, 64'(4 * (i - 1))); end
        checks++; if (decode_busy !== 1'b0) begin errors++; $display("FAIL stream_busy_%0d got 1 want 0", i); end
      end
      exec_ready = 1'b1;
      if (i < 8) begin
        fetch_valid = 1'b1;
        fetch_pkt   = mk_pkt(32'h0000_000F, 64'(4 * i), mk_insn(ADD, 5'(i), 5'd0, 14'd0));
      end else begin
        fetch_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %b want 0", exec_valid); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    exec_ready  = 1'b0;
    fetch_valid = 1'b1;
    fetch_pkt   = mk_pkt(32'h1, 64'h200, mk_insn(SUB, 5'd1, 5'd1, 14'd0));
    @(negedge clk);
    checks++; if (decode_busy !== 1'b0 || exec_pkt.pc !== 64'h200)
      begin errors++; $display("FAIL bp_one got busy %b pc %h want 0 200", decode_busy, exec_pkt.pc); end
    fetch_pkt = mk_pkt(32'h1, 64'h204, mk_insn(SUB, 5'd2, 5'd1, 14'd0));
    @(negedge clk);
    checks++; if (decode_busy !== 1'b1 || exec_pkt.pc !== 64'h200)
      begin errors++; $display("FAIL bp_full got busy %b pc %h want 1 200", decode_busy, exec_pkt.pc); end
    fetch_pkt = mk_pkt(32'h1, 64'h208, mk_insn(SUB, 5'd3, 5'd1, 14'd0));
    @(negedge clk);
    checks++; if (decode_busy !== 1'b1 || exec_valid !== 1'b1 || exec_pkt.pc !== 64'h200)
      begin errors++; $display("FAIL bp_hold got busy %b v %b pc %h want 1 1 200", decode_busy, exec_valid, exec_pkt.pc); end
    exec_ready = 1'b1;
    @(negedge clk);
    checks++; if (decode_busy !== 1'b0 || exec_pkt.pc !== 64'h204)
      begin errors++; $display("FAIL bp_drain1 got busy %b pc %h want 0 204", decode_busy, exec_pkt.pc); end
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++; if (exec_valid !== 1'b1 || exec_pkt.pc !== 64'h208)
      begin errors++; $display("FAIL bp_drain2 got v %b pc %h want 1 208", exec_valid, exec_pkt.pc); end
    @(negedge clk);
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", exec_valid); end
  endtask

  task automatic test_classes;
    send_one(mk_pkt(32'h0000_00FF, 64'h400, mk_insn(8'hEE, 5'd7, 5'd8, 14'h0123)));
    checks++; if (exec_pkt.illegal !== 1'b1 || exec_pkt.is_branch !== 1'b0 || exec_pkt.is_mem !== 1'b0 ||
                  exec_pkt.is_halt !== 1'b0 || exec_pkt.opcode !== 8'hEE || exec_pkt.rd !== 5'd7)
      begin errors++; $display("FAIL illegal got il%b b%b m%b h%b op %h", exec_pkt.illegal, exec_pkt.is_branch, exec_pkt.is_mem, exec_pkt.is_halt, exec_pkt.opcode); end
`ifdef DECODE_STATS_EN
    @(negedge clk);
    checks++; if (stat_illegal !== 32'd1) begin errors++; $display("FAIL stat_illegal got %0d want 1", stat_illegal); end
`endif
    send_one(mk_pkt(32'h1, 64'h410, mk_insn(HALT, 5'd0, 5'd0, 14'd0)));
    checks++; if (exec_pkt.is_halt !== 1'b1 || exec_pkt.is_branch !== 1'b0 || exec_pkt.illegal !== 1'b0)
      begin errors++; $display("FAIL halt got h%b b%b il%b want 1 0 0", exec_pkt.is_halt, exec_pkt.is_branch, exec_pkt.illegal); end
    send_one(mk_pkt(32'h1, 64'h414, mk_insn(LOAD, 5'd9, 5'd10, 14'd8)));
    checks++; if (exec_pkt.is_mem !== 1'b1 || exec_pkt.is_branch !== 1'b0)
      begin errors++; $display("FAIL load got m%b b%b want 1 0", exec_pkt.is_mem, exec_pkt.is_branch); end
    send_one(mk_pkt(32'h1, 64'h418, mk_insn(LOAD_RESTORE_PC, 5'd9, 5'd10, 14'd0)));
    checks++; if (exec_pkt.is_mem !== 1'b1 || exec_pkt.is_branch !== 1'b1 || exec_pkt.is_halt !== 1'b0)
      begin errors++; $display("FAIL lrpc got m%b b%b h%b want 1 1 0", exec_pkt.is_mem, exec_pkt.is_branch, exec_pkt.is_halt); end
  endtask

  task automatic test_reset_when_full;
    @(negedge clk);
    exec_ready  = 1'b0;
    fetch_valid = 1'b1;
    fetch_pkt   = mk_pkt(32'h1, 64'h500, mk_insn(ADD, 5'd1, 5'd2, 14'd0));
    @(negedge clk);
    fetch_pkt = mk_pkt(32'h1, 64'h504, mk_insn(ADD, 5'd1, 5'd2, 14'd0));
    @(negedge clk);
    checks++; if (decode_busy !== 1'b1) begin errors++; $display("FAIL rst_full_busy got %b want 1", decode_busy); end
    fetch_valid = 1'b0;
    reset_n     = 1'b0;
    @(negedge clk);
    checks++; if (exec_valid !== 1'b0 || decode_busy !== 1'b0)
      begin errors++; $display("FAIL rst_full got v %b busy %b want 0 0", exec_valid, decode_busy); end
    reset_n     = 1'b1;
    exec_ready  = 1'b1;
    fetch_valid = 1'b1;
    fetch_pkt   = mk_pkt(32'h1, 64'h300, mk_insn(MUL, 5'd4, 5'd5, 14'd0));
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++; if (exec_valid !== 1'b1 || exec_pkt.pc !== 64'h300)
      begin errors++; $display("FAIL rst_after got v %b pc %h want 1 300", exec_valid, exec_pkt.pc); end
    @(negedge clk);
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL rst_after_drain got %b want 0", exec_valid); end
  endtask

  initial begin
    test_reset();
    test_branch_fields();
    test_stream();
    test_backpressure();
    test_classes();
    test_reset_when_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
